// File: rtl/tile_seq_buffer_if.sv
// Stream and tile-read bundle for tile_seq_buffer.
//   slave  : the buffer (accepts words, serves tile reads)
//   master : the producer / PE-array side
// Write side : in_valid, in_ready, in_data, in_last, in_last_syms, in_complement
// Read side  : rd_tile_valid, rd_tile_len, rd_offset, rd_addr, rd_data, rd_release
// Status     : overflow (sticky until reset)
interface tile_seq_buffer_if #(
    parameter int SYM_WIDTH         = 8,
    parameter int SYMS_PER_WORD     = 4,
    parameter int MAX_TILE_SIZE     = 512,
    parameter int LOG_MAX_TILE_SIZE = $clog2(MAX_TILE_SIZE),
    parameter int LOG_SPW           = $clog2(SYMS_PER_WORD)
);
    logic                               in_valid;
    logic                               in_ready;
    logic [SYM_WIDTH*SYMS_PER_WORD-1:0] in_data;
    logic                               in_last;
    logic [LOG_SPW:0]                   in_last_syms;
    logic                               in_complement;
    logic                               rd_tile_valid;
    logic [LOG_MAX_TILE_SIZE:0]         rd_tile_len;
    logic [1:0]                         rd_offset;
    logic [LOG_MAX_TILE_SIZE:0]         rd_addr;
    logic [SYM_WIDTH-1:0]               rd_data;
    logic                               rd_release;
    logic                               overflow;

    modport slave (
        input  in_valid, in_data, in_last, in_last_syms, in_complement,
        input  rd_offset, rd_addr, rd_release,
        output in_ready, rd_tile_valid, rd_tile_len, rd_data, overflow
    );

    modport master (
        output in_valid, in_data, in_last, in_last_syms, in_complement,
        output rd_offset, rd_addr, rd_release,
        input  in_ready, rd_tile_valid, rd_tile_len, rd_data, overflow
    );
endinterface

// File: rtl/tile_seq_buffer.sv
// Multi-bank (ping-pong) sequence tile buffer. Packed symbol words are written
// into the bank at the write pointer while the PE array reads single symbols
// from the bank at the read pointer.
// Ports: clk, rst (sync, active high), bus (tile_seq_buffer_if.slave).
// Build option: define TILE_SEQ_BUFFER_REVCOMP_EN to make complemented tiles
// read back in reverse order (reverse complement).
//
// Write FSM states:
//   state   | meaning
//   W_IDLE  | waiting for the first beat of a tile
//   W_FILL  | tile in progress, beats written at word index wcnt
//   W_STALL | bank at the write pointer still holds an unreleased tile
module tile_seq_buffer #(
    parameter int SYM_WIDTH         = 8,
    parameter int SYMS_PER_WORD     = 4,
    parameter int MAX_TILE_SIZE     = 512,
    parameter int NUM_BANKS         = 2,
    parameter int LOG_MAX_TILE_SIZE = $clog2(MAX_TILE_SIZE),
    parameter int LOG_SPW           = $clog2(SYMS_PER_WORD)
) (
    input  logic               clk,
    input  logic               rst,
    tile_seq_buffer_if.slave   bus
);
    localparam int MAX_WORDS = MAX_TILE_SIZE / SYMS_PER_WORD;
    localparam int WA_W      = LOG_MAX_TILE_SIZE - LOG_SPW;
    localparam int WC_W      = WA_W + 1;
    localparam int LEN_W     = LOG_MAX_TILE_SIZE + 1;
    localparam int EFF_W     = LOG_MAX_TILE_SIZE + 2;
    localparam int LS_W      = LOG_SPW + 1;
    localparam int PTR_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WORD_W    = SYM_WIDTH * SYMS_PER_WORD;

    localparam logic [1:0] B_EMPTY   = 2'd0;
    localparam logic [1:0] B_FILLING = 2'd1;
    localparam logic [1:0] B_FULL    = 2'd2;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_FILL  = 2'd1;
    localparam logic [1:0] W_STALL = 2'd2;

    logic [1:0]       wstate;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WC_W-1:0]  wcnt;
    logic             comp_q;
    logic [1:0]       bank_state [NUM_BANKS];
    logic [LEN_W-1:0] bank_len   [NUM_BANKS];
`ifdef TILE_SEQ_BUFFER_REVCOMP_EN
    logic             bank_rev   [NUM_BANKS];
`endif
    logic [WORD_W-1:0] mem [NUM_BANKS][MAX_WORDS];

    logic             accept, at_cap, first_beat, close_tile, do_write;
    logic             comp_sel, release_head, in_range;
    logic [LS_W-1:0]  last_cnt;
    logic [LEN_W-1:0] new_len;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic [EFF_W-1:0] eff, raddr;
    logic [WA_W-1:0]  ridx;
    logic [LOG_SPW-1:0] lane;
    logic [SYM_WIDTH-1:0] rd_sym, rd_data_q;

    function automatic logic [SYM_WIDTH-1:0] comp_sym(input logic [SYM_WIDTH-1:0] s);
        case (s)
            SYM_WIDTH'(8'h41): return SYM_WIDTH'(8'h54);  // A -> T
            SYM_WIDTH'(8'h54): return SYM_WIDTH'(8'h41);  // T -> A
            SYM_WIDTH'(8'h43): return SYM_WIDTH'(8'h47);  // C -> G
            SYM_WIDTH'(8'h47): return SYM_WIDTH'(8'h43);  // G -> C
            SYM_WIDTH'(8'h61): return SYM_WIDTH'(8'h74);  // a -> t
            SYM_WIDTH'(8'h74): return SYM_WIDTH'(8'h61);  // t -> a
            SYM_WIDTH'(8'h63): return SYM_WIDTH'(8'h67);  // c -> g
            SYM_WIDTH'(8'h67): return SYM_WIDTH'(8'h63);  // g -> c
            default:           return s;
        endcase
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends only on registered state, so a release reaches it one
    // cycle later. W_STALL also accepts once the bank has drained.
    assign bus.in_ready      = !rst && ((wstate == W_FILL) || (bank_state[wr_ptr] == B_EMPTY));
    assign bus.rd_tile_valid = (bank_state[rd_ptr] == B_FULL);
    assign bus.rd_tile_len   = bus.rd_tile_valid ? bank_len[rd_ptr] : '0;
    assign bus.rd_data       = rd_data_q;

    assign accept       = bus.in_valid && bus.in_ready;
    assign at_cap       = (wcnt == WC_W'(MAX_WORDS));
    assign first_beat   = accept && (wstate != W_FILL);
    assign close_tile   = accept && (bus.in_last || at_cap);
    assign do_write     = accept && !at_cap;   // a beat past capacity is dropped
    assign comp_sel     = (wstate == W_FILL) ? comp_q : bus.in_complement;
    assign last_cnt     = (bus.in_last_syms == '0) ? LS_W'(SYMS_PER_WORD) : bus.in_last_syms;
    assign new_len      = at_cap ? LEN_W'(MAX_TILE_SIZE)
                                 : {wcnt, {LOG_SPW{1'b0}}} + LEN_W'(last_cnt);
    assign release_head = bus.rd_release && bus.rd_tile_valid;

    always_comb begin
        wr_word = bus.in_data;
        if (comp_sel) begin
            for (int l = 0; l < SYMS_PER_WORD; l++) begin
                wr_word[l*SYM_WIDTH +: SYM_WIDTH] = comp_sym(bus.in_data[l*SYM_WIDTH +: SYM_WIDTH]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate   <= W_IDLE;
            wr_ptr   <= '0;
            wcnt     <= '0;
            comp_q   <= 1'b0;
            bus.overflow <= 1'b0;
        end else if (accept) begin
            if (first_beat) begin
                comp_q <= bus.in_complement;
            end
            if (close_tile) begin
                wstate <= W_IDLE;
                wr_ptr <= next_ptr(wr_ptr);
                wcnt   <= '0;
                if (at_cap) begin
                    bus.overflow <= 1'b1;
                end
            end else begin
                wstate <= W_FILL;
                wcnt   <= wcnt + 1'b1;
            end
        end else if (wstate != W_FILL) begin
            wstate <= (bank_state[wr_ptr] == B_EMPTY) ? W_IDLE : W_STALL;
        end
    end

    // The write bank is EMPTY/FILLING and the read bank is FULL, so a
    // completion and a release can never target the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= B_EMPTY;
                bank_len[b]   <= '0;
`ifdef TILE_SEQ_BUFFER_REVCOMP_EN
                bank_rev[b]   <= 1'b0;
`endif
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (release_head && (rd_ptr == PTR_W'(b))) begin
                    bank_state[b] <= B_EMPTY;
                end else if (wr_ptr == PTR_W'(b)) begin
                    if (close_tile) begin
                        bank_state[b] <= B_FULL;
                        bank_len[b]   <= new_len;
`ifdef TILE_SEQ_BUFFER_REVCOMP_EN
                        bank_rev[b]   <= comp_sel;
`endif
                    end else if (first_beat) begin
                        bank_state[b] <= B_FILLING;
                    end
                end
            end
            if (release_head) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr][wcnt[WA_W-1:0]] <= wr_word;
        end
    end

    // Reversal is resolved at read time because tile_len is only known once
    // the tile has completed.
    always_comb begin
        eff      = EFF_W'(bus.rd_addr) + EFF_W'(bus.rd_offset);
        in_range = bus.rd_tile_valid && (eff < EFF_W'(bus.rd_tile_len));
`ifdef TILE_SEQ_BUFFER_REVCOMP_EN
        raddr    = bank_rev[rd_ptr] ? (EFF_W'(bus.rd_tile_len) - eff - EFF_W'(1)) : eff;
`else
        raddr    = eff;
`endif
        ridx     = WA_W'(raddr >> LOG_SPW);
        lane     = raddr[LOG_SPW-1:0];
        rd_word  = mem[rd_ptr][ridx];
        rd_sym   = '0;
        for (int l = 0; l < SYMS_PER_WORD; l++) begin
            if (lane == LOG_SPW'(l)) begin
                rd_sym = rd_word[l*SYM_WIDTH +: SYM_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= in_range ? rd_sym : '0;
        end
    end
endmodule
